// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin over NUM_REQ requesters, a registered
// write stage and a 32-entry pending-write scoreboard. Build option: RF_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps

module rf_wb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      alloc_valid,
    input  logic [4:0]                alloc_rd,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rf_write_enable,
    output logic [4:0]                rf_rd,
    output logic [DATA_W-1:0]         rf_write_data
);

    localparam int unsigned RD_W     = 5;
    localparam int unsigned NUM_REGS = 32;
`ifndef RF_ARB_FIXED_PRIO_EN
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`endif

    logic [NUM_REQ-1:0]  grant_c;
    logic                xfer_c;
    logic [RD_W-1:0]     win_rd_c;
    logic [DATA_W-1:0]   win_data_c;

    logic                rf_write_enable_q, rf_write_enable_d;
    logic [RD_W-1:0]     rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

`ifndef RF_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_idx_c;
`endif

    // Grant search: rotating from ptr+1 (round-robin) or from index 0 (fixed priority).
    always_comb begin : arb_comb
        int   idx;
        logic found;
        grant_c = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + 1 + k) % int'(NUM_REQ);
`endif
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!found && (i == idx) && req_valid[i]) begin
                    grant_c[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        if (!rst) begin
            grant_c = '0;
        end
    end

    assign req_ready = grant_c;

    // Winner payload mux.
    always_comb begin : win_mux
        xfer_c     = |grant_c;
        win_rd_c   = '0;
        win_data_c = '0;
`ifndef RF_ARB_FIXED_PRIO_EN
        win_idx_c  = ptr_q;
`endif
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i]) begin
                win_rd_c   = req_rd[i*RD_W +: RD_W];
                win_data_c = req_data[i*DATA_W +: DATA_W];
`ifndef RF_ARB_FIXED_PRIO_EN
                win_idx_c  = PTR_W'(i);
`endif
            end
        end
    end

    // Next state: write stage, scoreboard (set beats clear), pointer.
    always_comb begin : next_comb
        rf_write_enable_d = xfer_c && (win_rd_c != '0);
        rf_rd_d           = rf_rd_q;
        rf_write_data_d   = rf_write_data_q;
        if (rf_write_enable_d) begin
            rf_rd_d         = win_rd_c;
            rf_write_data_d = win_data_c;
        end

        busy_d = busy_q;
        if (rf_write_enable_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != '0)) begin
            busy_d[alloc_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

`ifndef RF_ARB_FIXED_PRIO_EN
        ptr_d = xfer_c ? win_idx_c : ptr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_enable_q <= 1'b0;
            rf_rd_q           <= '0;
            rf_write_data_q   <= '0;
            busy_q            <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr_q             <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            rf_write_enable_q <= rf_write_enable_d;
            rf_rd_q           <= rf_rd_d;
            rf_write_data_q   <= rf_write_data_d;
            busy_q            <= busy_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr_q             <= ptr_d;
`endif
        end
    end

    assign rf_write_enable = rf_write_enable_q;
    assign rf_rd           = rf_rd_q;
    assign rf_write_data   = rf_write_data_q;
    assign rs1_busy        = busy_q[rs1];
    assign rs2_busy        = busy_q[rs2];

endmodule
